bitty_seq_ctrl: RTL and testbench

Parametrised instruction sequencer for the bitty core. It replaces the fixed top-level control FSM with a configurable one. It owns the program counter, handshakes with the UART fetch unit and the bitty execution unit, and steers the shared UART between them. It adds instruction counting, a single-step/halt mode, an execution watchdog and an optional PC breakpoint.

---
 rtl/bitty_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_bitty_seq_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitty_seq_ctrl.sv
// bitty_seq_ctrl: configurable instruction sequencer for the bitty core.
// Owns the program counter, handshakes with the UART fetch unit and the execution
// unit, and steers the shared UART. Also counts retired instructions, supports
// single-step/halt, runs an execution watchdog and an optional PC breakpoint.
//
// Optional feature macro: BITTY_SEQ_BREAKPOINT_EN (compile in the PC breakpoint).
//
// Ports:
//   clk, reset       clock, synchronous active-low reset
//   fetch_done/instr fetch unit handshake and instruction word
//   next_pc          PC target from branch logic, loaded during PC update
//   exec_done        execution unit finished the current instruction
//   step_mode/resume halt after each instruction / leave halt
//   bp_addr/bp_en    breakpoint address and enable
//   pc, pc_en        current PC (fetch address) and one-cycle update strobe
//   instr_q          latched current instruction
//   run              one-cycle start pulse to the execution unit
//   uart_sel         0 = fetch unit owns UART, 1 = execution unit
//   stop_for_rw      hold fetch unit off the UART during memory/IO instructions
//   halted           sequencer is halted
//   timeout_err      watchdog fired, sticky until reset
//   instr_count      retired-instruction count, wraps silently
module bitty_seq_ctrl #(
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       INSTR_W     = 16,
  parameter int unsigned       CNT_W       = 16,
  parameter int unsigned       SETTLE_CYC  = 2,
  parameter int unsigned       TIMEOUT_CYC = 65535,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_done,
  input  logic [INSTR_W-1:0] instr,
  input  logic [ADDR_W-1:0]  next_pc,
  input  logic               exec_done,
  input  logic               step_mode,
  input  logic               resume,
  input  logic [ADDR_W-1:0]  bp_addr,
  input  logic               bp_en,
  output logic [ADDR_W-1:0]  pc,
  output logic               pc_en,
  output logic [INSTR_W-1:0] instr_q,
  output logic               run,
  output logic               uart_sel,
  output logic               stop_for_rw,
  output logic               halted,
  output logic               timeout_err,
  output logic [CNT_W-1:0]   instr_count
);

  localparam int unsigned WdW  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned SetW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [2:0] {
    StFetch, StDecode, StPcUpd, StSettle, StExec, StWait, StHalt, StErr
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_qq, instr_d;
  logic               rw_q, rw_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SetW-1:0]    settle_q, settle_d;
  logic [WdW-1:0]     wd_q, wd_d;
  logic               bp_hit;

`ifdef BITTY_SEQ_BREAKPOINT_EN
  // pc already holds the next fetch address once the instruction is in WAIT.
  assign bp_hit = bp_en && (pc_q == bp_addr);
`else
  logic unused_bp;
  assign unused_bp = ^{bp_addr, bp_en};
  assign bp_hit    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_qq;
    rw_d     = rw_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    wd_d     = wd_q;
    unique case (state_q)
      StFetch: begin
        if (fetch_done) begin
          instr_d = instr;
          state_d = StDecode;
        end
      end
      StDecode: begin
        rw_d    = (instr_qq[1:0] == 2'b11);
        state_d = StPcUpd;
      end
      StPcUpd: begin
        pc_d     = next_pc;
        settle_d = '0;
        state_d  = (SETTLE_CYC == 0) ? StExec : StSettle;
      end
      StSettle: begin
        if (settle_q == SetW'(SETTLE_CYC - 1)) begin
          state_d = StExec;
        end else begin
          settle_d = settle_q + SetW'(1);
        end
      end
      StExec: begin
        wd_d    = '0;
        state_d = StWait;
      end
      StWait: begin
        // exec_done wins over a watchdog expiry in the same cycle.
        if (exec_done) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = (step_mode || bp_hit) ? StHalt : StFetch;
        end else if (wd_q == WdW'(TIMEOUT_CYC)) begin
          state_d = StErr;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      StHalt: begin
        if (resume) begin
          state_d = StFetch;
        end
      end
      StErr: begin
        state_d = StErr;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StFetch;
      pc_q     <= RESET_PC;
      instr_qq <= '0;
      rw_q     <= 1'b0;
      cnt_q    <= '0;
      settle_q <= '0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_qq <= instr_d;
      rw_q     <= rw_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      wd_q     <= wd_d;
    end
  end

  // Moore decode of the registered state.
  assign pc          = pc_q;
  assign instr_q     = instr_qq;
  assign instr_count = cnt_q;
  assign pc_en       = (state_q == StPcUpd);
  assign run         = (state_q == StExec);
  assign uart_sel    = (state_q == StWait) && rw_q;
  assign stop_for_rw = (state_q == StWait) && rw_q;
  assign halted      = (state_q == StHalt);
  assign timeout_err = (state_q == StErr);

endmodule

// File: tb/tb_bitty_seq_ctrl.sv
module tb_bitty_seq_ctrl;

  localparam logic [7:0] RstPc = 8'h10;
`ifdef BITTY_SEQ_BREAKPOINT_EN
  localparam logic BpOn = 1'b1;
`else
  localparam logic BpOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_done;
  logic [15:0] instr;
  logic [7:0]  next_pc;
  logic        exec_done;
  logic        step_mode;
  logic        resume;
  logic [7:0]  bp_addr;
  logic        bp_en;
  logic [7:0]  pc;
  logic        pc_en;
  logic [15:0] instr_q;
  logic        run;
  logic        uart_sel;
  logic        stop_for_rw;
  logic        halted;
  logic        timeout_err;
  logic [1:0]  instr_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bitty_seq_ctrl #(
    .ADDR_W     (8),
    .INSTR_W    (16),
    .CNT_W      (2),
    .SETTLE_CYC (2),
    .TIMEOUT_CYC(10),
    .RESET_PC   (RstPc)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_done (fetch_done),
    .instr      (instr),
    .next_pc    (next_pc),
    .exec_done  (exec_done),
    .step_mode  (step_mode),
    .resume     (resume),
    .bp_addr    (bp_addr),
    .bp_en      (bp_en),
    .pc         (pc),
    .pc_en      (pc_en),
    .instr_q    (instr_q),
    .run        (run),
    .uart_sel   (uart_sel),
    .stop_for_rw(stop_for_rw),
    .halted     (halted),
    .timeout_err(timeout_err),
    .instr_count(instr_count)
  );

  typedef struct {
    logic [15:0] ins;
    logic [7:0]  npc;
    int          delay;  // run-to-exec_done distance in cycles
    logic        spur;   // spurious exec_done during SETTLE
    logic        rw;
    logic [1:0]  cnt;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    fetch_done = 1'b0;
    exec_done  = 1'b0;
    resume     = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // Drives cycles 0..5 of an instruction; returns in the run cycle.
  task automatic start_instr(input logic [15:0] ins, input logic [7:0] npc, input logic spur,
                             input logic [1:0] cnt_before);
    logic [7:0] old_pc;
    old_pc     = pc;
    fetch_done = 1'b1;
    instr      = ins;
    next_pc    = npc;
    check("c0_pc_en", pc_en, 0);
    check("c0_run", run, 0);
    tick();
    fetch_done = 1'b0;
    instr      = ~ins;
    check("c1_instr_q", instr_q, ins);
    check("c1_pc_en", pc_en, 0);
    tick();
    check("c2_pc_en", pc_en, 1);
    check("c2_pc_old", pc, old_pc);
    tick();
    check("c3_pc_new", pc, npc);
    check("c3_pc_en", pc_en, 0);
    check("c3_run", run, 0);
    exec_done = spur;
    next_pc   = ~npc;
    tick();
    exec_done = 1'b0;
    check("c4_run", run, 0);
    check("c4_count", instr_count, cnt_before);
    tick();
    check("c5_run", run, 1);
    check("c5_pc", pc, npc);
    check("c5_uart_sel", uart_sel, 0);
  endtask

  // From the run cycle: wait, retire, and check the post-retire state.
  task automatic finish_instr(input int delay, input logic rw, input logic [1:0] cnt,
                              input logic halt);
    for (int i = 1; i < delay; i++) begin
      tick();
      check("wait_uart_sel", uart_sel, rw);
      check("wait_stop_for_rw", stop_for_rw, rw);
      check("wait_run", run, 0);
    end
    tick();
    exec_done = 1'b1;
    check("done_uart_sel", uart_sel, rw);
    check("done_timeout_err", timeout_err, 0);
    tick();
    exec_done = 1'b0;
    check("ret_count", instr_count, cnt);
    check("ret_uart_sel", uart_sel, 0);
    check("ret_stop_for_rw", stop_for_rw, 0);
    check("ret_halted", halted, halt);
    check("ret_timeout_err", timeout_err, 0);
  endtask

  initial begin
    tbl[0] = '{16'h0001, 8'h01, 3, 1'b0, 1'b0, 2'd1};
    tbl[1] = '{16'h0003, 8'h02, 5, 1'b0, 1'b1, 2'd2};
    tbl[2] = '{16'h8013, 8'h7f, 1, 1'b1, 1'b1, 2'd3};
    tbl[3] = '{16'hfffe, 8'h80, 2, 1'b0, 1'b0, 2'd0};
    tbl[4] = '{16'h1237, 8'h33, 4, 1'b0, 1'b1, 2'd1};
    tbl[5] = '{16'h4442, 8'h10, 11, 1'b1, 1'b0, 2'd2};  // exec_done beats watchdog

    reset      = 1'b0;
    fetch_done = 1'b0;
    instr      = '0;
    next_pc    = '0;
    exec_done  = 1'b0;
    step_mode  = 1'b0;
    resume     = 1'b0;
    bp_addr    = '0;
    bp_en      = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    check("rst_pc", pc, RstPc);
    check("rst_instr_q", instr_q, 0);
    check("rst_count", instr_count, 0);
    check("rst_pc_en", pc_en, 0);
    check("rst_run", run, 0);
    check("rst_uart_sel", uart_sel, 0);
    check("rst_stop_for_rw", stop_for_rw, 0);
    check("rst_halted", halted, 0);
    check("rst_timeout_err", timeout_err, 0);

    for (int i = 0; i < 6; i++) begin
      start_instr(tbl[i].ins, tbl[i].npc, tbl[i].spur, (i == 0) ? 2'd0 : tbl[i-1].cnt);
      finish_instr(tbl[i].delay, tbl[i].rw, tbl[i].cnt, 1'b0);
    end

    // Single-step: halt after each instruction, resume restarts fetch.
    do_reset();
    step_mode = 1'b1;
    start_instr(16'h0005, 8'h21, 1'b0, 2'd0);
    finish_instr(2, 1'b0, 2'd1, 1'b1);
    fetch_done = 1'b1;
    exec_done  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halt_stays", halted, 1);
      check("halt_pc", pc, 8'h21);
      check("halt_count", instr_count, 1);
      check("halt_run", run, 0);
    end
    fetch_done = 1'b0;
    exec_done  = 1'b0;
    resume     = 1'b1;
    tick();
    resume = 1'b0;
    check("resume_halted", halted, 0);
    start_instr(16'h0007, 8'h22, 1'b0, 2'd1);
    finish_instr(3, 1'b1, 2'd2, 1'b1);
    step_mode = 1'b0;
    resume    = 1'b1;
    tick();
    resume = 1'b0;
    check("resume2_halted", halted, 0);

    // Breakpoint at pc 4 (ignored when the feature is not built).
    do_reset();
    bp_en   = 1'b1;
    bp_addr = 8'h04;
    start_instr(16'h0001, 8'h02, 1'b0, 2'd0);
    finish_instr(2, 1'b0, 2'd1, 1'b0);
    start_instr(16'h0001, 8'h04, 1'b0, 2'd1);
    finish_instr(2, 1'b0, 2'd2, BpOn);
`ifdef BITTY_SEQ_BREAKPOINT_EN
    check("bp_pc", pc, 8'h04);
    resume = 1'b1;
    tick();
    resume = 1'b0;
`endif
    start_instr(16'h0001, 8'h05, 1'b0, 2'd2);
    finish_instr(2, 1'b0, 2'd3, 1'b0);
    bp_en = 1'b0;

    // Watchdog: no exec_done, error 12 cycles after run, sticky until reset.
    do_reset();
    start_instr(16'h0003, 8'h44, 1'b0, 2'd0);
    for (int i = 1; i <= 11; i++) begin
      tick();
      check("wd_no_err", timeout_err, 0);
      check("wd_uart_sel", uart_sel, 1);
    end
    tick();
    check("wd_err", timeout_err, 1);
    check("wd_err_uart_sel", uart_sel, 0);
    check("wd_err_halted", halted, 0);
    exec_done  = 1'b1;
    fetch_done = 1'b1;
    resume     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wd_sticky", timeout_err, 1);
      check("wd_count", instr_count, 0);
      check("wd_run", run, 0);
    end
    do_reset();
    check("wd_rst_err", timeout_err, 0);
    check("wd_rst_pc", pc, RstPc);

    // Reset mid-SETTLE aborts the instruction.
    fetch_done = 1'b1;
    instr      = 16'h0003;
    next_pc    = 8'h55;
    tick();
    fetch_done = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("settle_rst_pc", pc, RstPc);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("settle_rst_run", run, 0);
    end

    // Reset mid-WAIT aborts with no count increment.
    start_instr(16'h0003, 8'h66, 1'b0, 2'd0);
    tick();
    reset     = 1'b0;
    exec_done = 1'b1;
    tick();
    reset     = 1'b1;
    exec_done = 1'b0;
    check("wait_rst_count", instr_count, 0);
    check("wait_rst_uart_sel", uart_sel, 0);
    check("wait_rst_pc", pc, RstPc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
